// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one restoring divider among NREQ requesters.
// Optional WAIT watchdog: define DIVARB_TIMEOUT_EN.
module divider_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_dividend,
    input  logic [NREQ*WIDTH-1:0] req_divider,
    input  logic [NREQ-1:0]       req_sign,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      quotient,
    output logic [WIDTH-1:0]      remainder,
    output logic                  div_by_zero,
    output logic                  timeout,
    output logic                  busy,
    output logic                  div_start,
    output logic [WIDTH-1:0]      div_dividend,
    output logic [WIDTH-1:0]      div_divider,
    output logic                  div_sign,
    input  logic                  div_ready,
    input  logic [WIDTH-1:0]      div_quotient,
    input  logic [WIDTH-1:0]      div_remainder
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic             zero_q, zero_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             start_q, start_d;
    logic             busy_q;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_q, sgn_d;
`ifdef DIVARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;
    logic [WIDTH-1:0] win_dividend;
    logic [WIDTH-1:0] win_divider;
    logic             win_sign;
    logic [NREQ-1:0]  win_oh;
    logic [NREQ-1:0]  owner_oh;

    // Walk downward so the nearest set bit after last_q is the one that sticks.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_dividend = '0;
        win_divider  = '0;
        win_sign     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_dividend = req_dividend[i*WIDTH +: WIDTH];
                win_divider  = req_divider[i*WIDTH +: WIDTH];
                win_sign     = req_sign[i];
            end
        end
    end

    assign win_oh   = NREQ'(1) << win_idx;
    assign owner_oh = NREQ'(1) << owner_q;

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        zero_d  = zero_q;
        grant_d = '0;
        done_d  = '0;
        start_d = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        sgn_d   = sgn_q;
`ifdef DIVARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                    last_d  = win_idx;
                    owner_d = win_idx;
                    grant_d = win_oh;
                    dvd_d   = win_dividend;
                    dvs_d   = win_divider;
                    sgn_d   = win_sign;
                    zero_d  = (win_divider == '0);
                    start_d = (win_divider != '0);
                end
            end
            ISSUE: begin
                // A zero divisor skips the divider but still spends this cycle so done trails grant by one.
                if (zero_q) begin
                    state_d = DONE;
                    done_d  = owner_oh;
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
`ifdef DIVARB_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end else begin
                    state_d = WAIT;
`ifdef DIVARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (div_ready) begin
                    state_d = DONE;
                    done_d  = owner_oh;
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    dbz_d   = 1'b0;
`ifdef DIVARB_TIMEOUT_EN
                    tmo_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    done_d  = owner_oh;
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            zero_q  <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            sgn_q   <= 1'b0;
`ifdef DIVARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            zero_q  <= zero_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            start_q <= start_d;
            busy_q  <= (state_d != IDLE);
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            sgn_q   <= sgn_d;
`ifdef DIVARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign div_start    = start_q;
    assign busy         = busy_q;
    assign quotient     = quot_q;
    assign remainder    = rem_q;
    assign div_by_zero  = dbz_q;
    assign div_dividend = dvd_q;
    assign div_divider  = dvs_q;
    assign div_sign     = sgn_q;
`ifdef DIVARB_TIMEOUT_EN
    assign timeout      = tmo_q;
`else
    // Constant 0; TIMEOUT has no effect in this build.
    assign timeout      = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a behavioural divider answering WIDTH+1 cycles after start.
`timescale 1ns/1ps
module tb_divider_arbiter;
    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = WIDTH + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_dividend, req_divider;
    logic [NREQ-1:0]       req_sign;
    logic [NREQ-1:0]       grant, done;
    logic [WIDTH-1:0]      quotient, remainder;
    logic                  div_by_zero, timeout, busy, div_start, div_sign;
    logic [WIDTH-1:0]      div_dividend, div_divider;
    logic                  div_ready = 1'b0;
    logic [WIDTH-1:0]      div_quotient = '0, div_remainder = '0;

    divider_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_dividend(req_dividend),
        .req_divider(req_divider), .req_sign(req_sign), .grant(grant), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .timeout(timeout), .busy(busy), .div_start(div_start),
        .div_dividend(div_dividend), .div_divider(div_divider), .div_sign(div_sign),
        .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    typedef struct { int idx; logic start; int cyc; } grant_exp_t;
    typedef struct { int idx; logic [WIDTH-1:0] q; logic [WIDTH-1:0] r; logic dbz; logic to; int gap; } done_exp_t;

    grant_exp_t gq[$];
    done_exp_t  dq[$];
    int  checks = 0, failures = 0;
    int  cyc = 0, grant_cyc = 0, m_cnt = 0;
    bit  in_txn = 0, withhold = 0, stray_tgl = 0, stray_seen = 0;
    logic [NREQ-1:0] hold = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: sees start mid-cycle, raises ready for one cycle LAT cycles later.
    always @(negedge clk) begin
        div_ready = 1'b0;
        if (stray_tgl != stray_seen) begin
            div_ready  = 1'b1;
            stray_seen = stray_tgl;
        end else if (div_start) begin
            m_cnt = LAT;
            if (div_divider == '0) begin
                div_quotient  = '1;
                div_remainder = div_dividend;
            end else if (div_sign) begin
                div_quotient  = $signed(div_dividend) / $signed(div_divider);
                div_remainder = $signed(div_dividend) % $signed(div_divider);
            end else begin
                div_quotient  = div_dividend / div_divider;
                div_remainder = div_dividend % div_divider;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0 && !withhold) div_ready = 1'b1;
        end
    end

    // Monitor: pops expectations whenever grant or done is presented.
    always @(negedge clk) begin
        grant_exp_t g;
        done_exp_t  d;
        if (reset) begin
            in_txn = 0;
        end else begin
            if (grant != '0) begin
                if (gq.size() == 0) check("grant_unexpected", 64'(grant), 64'(0));
                else begin
                    g = gq.pop_front();
                    check("grant_onehot", 64'(grant), 64'(1) << g.idx);
                    check("grant_div_start", 64'(div_start), 64'(g.start));
                    if (g.cyc >= 0) check("grant_cycle", 64'(cyc), 64'(g.cyc));
                    check("grant_before_prev_done", 64'(in_txn), 64'(0));
                end
                grant_cyc = cyc;
                in_txn    = 1;
            end else if (div_start) begin
                check("div_start_without_grant", 64'(div_start), 64'(0));
            end
            if (done != '0) begin
                if (dq.size() == 0) check("done_unexpected", 64'(done), 64'(0));
                else begin
                    d = dq.pop_front();
                    check("done_onehot", 64'(done), 64'(1) << d.idx);
                    check("done_quotient", 64'(quotient), 64'(d.q));
                    check("done_remainder", 64'(remainder), 64'(d.r));
                    check("done_div_by_zero", 64'(div_by_zero), 64'(d.dbz));
                    check("done_timeout", 64'(timeout), 64'(d.to));
                    if (d.gap >= 0) check("done_latency", 64'(cyc - grant_cyc), 64'(d.gap));
                end
                in_txn = 0;
            end
        end
    end

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        req_dividend[i*WIDTH +: WIDTH] = a;
        req_divider[i*WIDTH +: WIDTH]  = b;
        req_sign[i]                    = s;
    endtask

    task automatic run_until_grants(input int n, input int budget);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (grant != '0) begin
                seen++;
                req = req & ~(grant & ~hold);
            end
        end
        check("grant_wait_expired", 64'(seen < n), 64'(0));
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((gq.size() != 0 || dq.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain_wait_expired", 64'(gq.size() != 0 || dq.size() != 0 || busy), 64'(0));
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_grant"}, 64'(grant), 64'(0));
        check({p, "_done"}, 64'(done), 64'(0));
        check({p, "_div_start"}, 64'(div_start), 64'(0));
        check({p, "_busy"}, 64'(busy), 64'(0));
        check({p, "_timeout"}, 64'(timeout), 64'(0));
        check({p, "_div_by_zero"}, 64'(div_by_zero), 64'(0));
        check({p, "_quotient"}, 64'(quotient), 64'(0));
        check({p, "_remainder"}, 64'(remainder), 64'(0));
        check({p, "_div_dividend"}, 64'(div_dividend), 64'(0));
        check({p, "_div_divider"}, 64'(div_divider), 64'(0));
        check({p, "_div_sign"}, 64'(div_sign), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req = '0; req_dividend = '0; req_divider = '0; req_sign = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single unsigned divide with exact timing.
        set_op(0, 100, 7, 1'b0);
        gq.push_back('{0, 1'b1, cyc + 1});
        dq.push_back('{0, 32'd14, 32'd2, 1'b0, 1'b0, LAT + 1});
        req[0] = 1'b1;
        run_until_grants(1, 10);
        wait_drain(100);

        // All four requesting after reset: served 0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_op(i, 1000, 10 * (i + 1), 1'b0);
            gq.push_back('{i, 1'b1, -1});
        end
        dq.push_back('{0, 32'd100, 32'd0,  1'b0, 1'b0, LAT + 1});
        dq.push_back('{1, 32'd50,  32'd0,  1'b0, 1'b0, LAT + 1});
        dq.push_back('{2, 32'd33,  32'd10, 1'b0, 1'b0, LAT + 1});
        dq.push_back('{3, 32'd25,  32'd0,  1'b0, 1'b0, LAT + 1});
        req = '1;
        run_until_grants(4, 400);
        wait_drain(100);

        // Zero divisor: no div_start, done one cycle after grant.
        set_op(2, 55, 0, 1'b0);
        gq.push_back('{2, 1'b0, cyc + 1});
        dq.push_back('{2, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0, 1});
        req[2] = 1'b1;
        run_until_grants(1, 10);
        wait_drain(20);

        // Signed -100 / 7.
        set_op(1, 32'hFFFF_FF9C, 7, 1'b1);
        gq.push_back('{1, 1'b1, cyc + 1});
        dq.push_back('{1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, LAT + 1});
        req[1] = 1'b1;
        run_until_grants(1, 10);
        wait_drain(100);

        // Two held requesters alternate; reset lands in WAIT of the fifth transaction.
        do_reset();
        set_op(0, 20, 4, 1'b0);
        set_op(3, 23, 5, 1'b0);
        hold = 4'b1001;
        for (int i = 0; i < 5; i++) gq.push_back('{(i % 2 == 0) ? 0 : 3, 1'b1, -1});
        for (int i = 0; i < 2; i++) begin
            dq.push_back('{0, 32'd5, 32'd0, 1'b0, 1'b0, LAT + 1});
            dq.push_back('{3, 32'd4, 32'd3, 1'b0, 1'b0, LAT + 1});
        end
        req = 4'b1001;
        run_until_grants(5, 400);
        repeat (5) @(negedge clk);
        check("busy_in_wait", 64'(busy), 64'(1));
        req[0] = 1'b0;
        hold   = '0;
        reset  = 1'b1;
        @(negedge clk);
        check_all_zero("midwait_reset");
        @(negedge clk);
        gq.push_back('{3, 1'b1, cyc + 1});
        dq.push_back('{3, 32'd4, 32'd3, 1'b0, 1'b0, LAT + 1});
        reset = 1'b0;
        run_until_grants(1, 10);
        wait_drain(100);

        // Stray ready while idle must not produce a done or alter results.
        stray_tgl = ~stray_tgl;
        repeat (4) @(negedge clk);
        check("stray_busy", 64'(busy), 64'(0));
        check("stray_quotient", 64'(quotient), 64'(4));

`ifdef DIVARB_TIMEOUT_EN
        // Withheld ready: timeout exactly TIMEOUT cycles after entering WAIT.
        withhold = 1'b1;
        set_op(1, 9, 3, 1'b0);
        gq.push_back('{1, 1'b1, cyc + 1});
        dq.push_back('{1, 32'd0, 32'd0, 1'b0, 1'b1, TIMEOUT + 1});
        req[1] = 1'b1;
        run_until_grants(1, 10);
        wait_drain(TIMEOUT + 20);
        stray_tgl = ~stray_tgl;
        repeat (4) @(negedge clk);
        check("late_ready_busy", 64'(busy), 64'(0));
        check("late_ready_quotient", 64'(quotient), 64'(0));
        withhold = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
